// File: rtl/omsp_spm_pkg.sv
// rtl/omsp_spm_pkg.sv - shared encodings for the sequential SPM controller
package omsp_spm_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Each slot packs {pub_start, pub_end, sec_start, sec_end}, so sec_end sits in the slot LSBs.
  localparam int BND_SEC_END   = 0;
  localparam int BND_SEC_START = 1;
  localparam int BND_PUB_END   = 2;
  localparam int BND_PUB_START = 3;
  localparam int BND_FIELDS    = 4;

  function automatic int bnd_lsb(input int slot, input int field, input int addr_w);
    return (slot * BND_FIELDS + field) * addr_w;
  endfunction

endpackage

// File: rtl/omsp_spm_range_overlap.sv
// rtl/omsp_spm_range_overlap.sv - intersection test between two pairs of half-open ranges
module omsp_spm_range_overlap #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] a0_start,
  input  logic [ADDR_W-1:0] a0_end,
  input  logic [ADDR_W-1:0] a1_start,
  input  logic [ADDR_W-1:0] a1_end,
  input  logic [ADDR_W-1:0] b0_start,
  input  logic [ADDR_W-1:0] b0_end,
  input  logic [ADDR_W-1:0] b1_start,
  input  logic [ADDR_W-1:0] b1_end,
  output logic              overlap
);

  // An empty range never intersects anything, even if its bounds straddle the other range.
  function automatic logic hit(input logic [ADDR_W-1:0] s0, input logic [ADDR_W-1:0] e0,
                               input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] e1);
    return (s0 < e0) && (s1 < e1) && (s0 < e1) && (s1 < e0);
  endfunction

  assign overlap = hit(a0_start, a0_end, b0_start, b0_end)
                 | hit(a0_start, a0_end, b1_start, b1_end)
                 | hit(a1_start, a1_end, b0_start, b0_end)
                 | hit(a1_start, a1_end, b1_start, b1_end);

endmodule

// File: rtl/omsp_spm_seq_control.sv
// rtl/omsp_spm_seq_control.sv - sequential SPM create/destroy controller, ID counter, prev-PC tracker
module omsp_spm_seq_control
  import omsp_spm_pkg::*;
#(
  parameter int NB_SPMS = 4,
  parameter int ID_W    = 16,
  parameter int ADDR_W  = 16
) (
  input  logic                           mclk,
  input  logic                           puc_rst_n,
  input  logic [ADDR_W-1:0]              pc,
  input  logic                           req_valid,
  input  logic                           req_enable,
  output logic                           req_ready,
  input  logic [ADDR_W-1:0]              pub_start,
  input  logic [ADDR_W-1:0]              pub_end,
  input  logic [ADDR_W-1:0]              sec_start,
  input  logic [ADDR_W-1:0]              sec_end,
  input  logic [NB_SPMS-1:0]             slot_enabled,
  input  logic [NB_SPMS*4*ADDR_W-1:0]    slot_bounds,
  input  logic [NB_SPMS-1:0]             slot_owner,
  input  logic [NB_SPMS-1:0]             slot_violation,
  output logic [NB_SPMS-1:0]             slot_update,
  output logic [NB_SPMS-1:0]             slot_disable,
  output logic [ID_W-1:0]                new_id,
  output logic [ADDR_W-1:0]              prev_pc,
  output logic                           done_valid,
  output logic                           done_ok,
  output logic [ID_W-1:0]                done_id,
  output logic                           id_exhausted,
  output logic                           violation
);

  localparam int IDX_W = (NB_SPMS > 1) ? $clog2(NB_SPMS) : 1;

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   alloc_q, alloc_d;
  logic               is_create_q, is_create_d;
  logic [NB_SPMS-1:0] owner_q, owner_d;
  logic [ADDR_W-1:0]  npub_start_q, npub_start_d;
  logic [ADDR_W-1:0]  npub_end_q, npub_end_d;
  logic [ADDR_W-1:0]  nsec_start_q, nsec_start_d;
  logic [ADDR_W-1:0]  nsec_end_q, nsec_end_d;
  logic               ok_q, ok_d;
  logic [ID_W-1:0]    res_id_q, res_id_d;
  logic [ID_W-1:0]    next_id_q, next_id_d;
  logic               exh_q, exh_d;
  logic [ADDR_W-1:0]  cur_pc_q, cur_pc_d;
  logic [ADDR_W-1:0]  prev_pc_q, prev_pc_d;

  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               layout_ovl;
  logic               slot_ovl;
  logic               chk_en;
  logic [ADDR_W-1:0]  chk_pub_start, chk_pub_end, chk_sec_start, chk_sec_end;

  // Descending scan so the lowest free slot is the one left standing.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NB_SPMS - 1; i >= 0; i--) begin
      if (!slot_enabled[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  omsp_spm_range_overlap #(.ADDR_W(ADDR_W)) u_layout_ovl (
    .a0_start (pub_start),
    .a0_end   (pub_end),
    .a1_start (pub_start),
    .a1_end   (pub_end),
    .b0_start (sec_start),
    .b0_end   (sec_end),
    .b1_start (sec_start),
    .b1_end   (sec_end),
    .overlap  (layout_ovl)
  );

  always_comb begin
    chk_en        = 1'b0;
    chk_pub_start = '0;
    chk_pub_end   = '0;
    chk_sec_start = '0;
    chk_sec_end   = '0;
    for (int i = 0; i < NB_SPMS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        chk_en        = slot_enabled[i] && (alloc_q != IDX_W'(i));
        chk_pub_start = slot_bounds[bnd_lsb(i, BND_PUB_START, ADDR_W) +: ADDR_W];
        chk_pub_end   = slot_bounds[bnd_lsb(i, BND_PUB_END, ADDR_W) +: ADDR_W];
        chk_sec_start = slot_bounds[bnd_lsb(i, BND_SEC_START, ADDR_W) +: ADDR_W];
        chk_sec_end   = slot_bounds[bnd_lsb(i, BND_SEC_END, ADDR_W) +: ADDR_W];
      end
    end
  end

  omsp_spm_range_overlap #(.ADDR_W(ADDR_W)) u_slot_ovl (
    .a0_start (npub_start_q),
    .a0_end   (npub_end_q),
    .a1_start (nsec_start_q),
    .a1_end   (nsec_end_q),
    .b0_start (chk_pub_start),
    .b0_end   (chk_pub_end),
    .b1_start (chk_sec_start),
    .b1_end   (chk_sec_end),
    .overlap  (slot_ovl)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    alloc_d      = alloc_q;
    is_create_d  = is_create_q;
    owner_d      = owner_q;
    npub_start_d = npub_start_q;
    npub_end_d   = npub_end_q;
    nsec_start_d = nsec_start_q;
    nsec_end_d   = nsec_end_q;
    ok_d         = ok_q;
    res_id_d     = res_id_q;
    next_id_d    = next_id_q;
    exh_d        = exh_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          is_create_d  = req_enable;
          owner_d      = slot_owner;
          alloc_d      = free_idx;
          npub_start_d = pub_start;
          npub_end_d   = pub_end;
          nsec_start_d = sec_start;
          nsec_end_d   = sec_end;
          idx_d        = '0;
          ok_d         = 1'b0;
          res_id_d     = '0;
          if (req_enable) begin
            if ((pub_start >= pub_end) || (sec_start >= sec_end) || layout_ovl ||
                !free_found || exh_q) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_CHECK;
            end
          end else begin
            state_d = (slot_owner != '0) ? ST_COMMIT : ST_DONE;
          end
        end
      end
      ST_CHECK: begin
        if (chk_en && slot_ovl) begin
          state_d = ST_DONE;
        end else if (idx_q == IDX_W'(NB_SPMS - 1)) begin
          state_d = ST_COMMIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        ok_d    = 1'b1;
        state_d = ST_DONE;
        if (is_create_q) begin
          res_id_d  = next_id_q;
          next_id_d = next_id_q + 1'b1;
          if (&next_id_q) begin
            exh_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    cur_pc_d  = cur_pc_q;
    prev_pc_d = prev_pc_q;
    if (pc != cur_pc_q) begin
      prev_pc_d = cur_pc_q;
      cur_pc_d  = pc;
    end
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      alloc_q      <= '0;
      is_create_q  <= 1'b0;
      owner_q      <= '0;
      npub_start_q <= '0;
      npub_end_q   <= '0;
      nsec_start_q <= '0;
      nsec_end_q   <= '0;
      ok_q         <= 1'b0;
      res_id_q     <= '0;
      next_id_q    <= ID_W'(1);
      exh_q        <= 1'b0;
      cur_pc_q     <= '0;
      prev_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      alloc_q      <= alloc_d;
      is_create_q  <= is_create_d;
      owner_q      <= owner_d;
      npub_start_q <= npub_start_d;
      npub_end_q   <= npub_end_d;
      nsec_start_q <= nsec_start_d;
      nsec_end_q   <= nsec_end_d;
      ok_q         <= ok_d;
      res_id_q     <= res_id_d;
      next_id_q    <= next_id_d;
      exh_q        <= exh_d;
      cur_pc_q     <= cur_pc_d;
      prev_pc_q    <= prev_pc_d;
    end
  end

  always_comb begin
    slot_update  = '0;
    slot_disable = '0;
    new_id       = '0;
    if (state_q == ST_COMMIT) begin
      if (is_create_q) begin
        for (int i = 0; i < NB_SPMS; i++) begin
          slot_update[i] = (alloc_q == IDX_W'(i));
        end
        new_id = next_id_q;
      end else begin
        slot_disable = owner_q;
      end
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign done_valid   = (state_q == ST_DONE);
  assign done_ok      = done_valid & ok_q;
  assign done_id      = done_valid ? res_id_q : '0;
  assign prev_pc      = prev_pc_q;
  assign id_exhausted = exh_q;
  assign violation    = (|slot_violation) | exh_q;

endmodule
